// File: rtl/mii_rx_deframer.sv
// mii_rx_deframer
// Oversamples an MII receive interface in the clk domain, strips the
// preamble/SFD, packs nibbles into bytes and delivers them through a
// first-word-fall-through FIFO tagged with end-of-frame and error flags.
//
// Optional feature: define MII_CRC_EN to check the frame's CRC-32 and
// flag a bad residue on the final byte's err tag.
//
// Ports
//   clk, reset          system clock (>=4x mii_clk), synchronous active-high reset
//   mii_clk/en/d        raw MII receive pins, asynchronous to clk
//   rdy, d, last, err   FIFO head: valid flag, byte, end-of-frame, frame error
//   ack                 pop the head entry (ignored while rdy=0)
//   error               sticky overflow flag, cleared only by reset
//   level               current FIFO occupancy
module mii_rx_deframer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PRE_MIN     = 2,
    parameter int unsigned FIRST_HIGH  = 1,
    parameter int unsigned BIT_REVERSE = 1,
    parameter int unsigned DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mii_clk,
    input  logic                     mii_en,
    input  logic [3:0]               mii_d,
    output logic                     rdy,
    output logic [7:0]               d,
    output logic                     last,
    output logic                     err,
    input  logic                     ack,
    output logic                     error,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(PRE_MIN + 2);
    localparam int unsigned EW = 10;   // {last, err, byte}

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_DISCARD
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers: {mii_clk, mii_en, mii_d} travel through the same
    // number of stages so the sampled data lines up with the clock edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
    logic                        clk_prev_q, clk_prev_d;
    logic                        s_clk_c, s_en_c, sample_c;
    logic [3:0]                  s_d_c;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], {mii_clk, mii_en, mii_d}};
        clk_prev_d = s_clk_c;
    end

    assign s_clk_c  = sync_q[SYNC_STAGES-1][5];
    assign s_en_c   = sync_q[SYNC_STAGES-1][4];
    assign s_d_c    = sync_q[SYNC_STAGES-1][3:0];
    assign sample_c = s_clk_c & ~clk_prev_q;

    // ------------------------------------------------------------------
    // Nibble to byte assembly
    // ------------------------------------------------------------------
    function automatic logic [3:0] slot(input logic [3:0] n);
        if (BIT_REVERSE != 0) begin
            return {n[0], n[1], n[2], n[3]};
        end
        return n;
    endfunction

    logic [3:0] nib_q, nib_d;
    logic [7:0] byte_c;

    assign byte_c = (FIRST_HIGH != 0) ? {slot(nib_q), slot(s_d_c)}
                                      : {slot(s_d_c), slot(nib_q)};

    // ------------------------------------------------------------------
    // Optional CRC-32 over DATA nibbles in wire order (mii_d[0] first)
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   crc_bad_c;

`ifdef MII_CRC_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 4; i++) begin
            fb = r[0] ^ n[i];
            r  = r >> 1;
            if (fb) begin
                r = r ^ 32'hEDB8_8320;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Preset on every preamble sample so the SFD leaves it at all ones.
    always_comb begin
        crc_d = crc_q;
        if (sample_c && state_q == S_PRE) begin
            crc_d = '1;
        end else if (sample_c && state_q == S_DATA && s_en_c) begin
            crc_d = crc_nib(crc_q, s_d_c);
        end
    end

    // The shift-right register holds the residue in reflected form.
    assign crc_bad_c = (rev32(crc_q) != 32'hC704_DD7B);

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '1;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    assign crc_bad_c = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          half_q, half_d;
    logic [7:0]    pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic          error_q, error_d;
    logic          wr_req_c;
    logic [EW-1:0] wr_data_c;
    logic          pop_c, wr_ok_c, wr_en_c;
    logic [LW-1:0] count_q, count_d;

    assign pop_c   = ack && (count_q != '0);
    assign wr_ok_c = (count_q != LW'(DEPTH)) || pop_c;
    assign wr_en_c = wr_req_c && wr_ok_c;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        nib_d      = nib_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        error_d    = error_q;
        wr_req_c   = 1'b0;
        wr_data_c  = '0;

        if (sample_c) begin
            case (state_q)
                S_IDLE: begin
                    if (s_en_c) begin
                        if (s_d_c == 4'h5) begin
                            state_d = S_PRE;
                            cnt_d   = CW'(1);
                        end else begin
                            state_d = S_DISCARD;
                        end
                    end
                end

                S_PRE: begin
                    if (!s_en_c) begin
                        state_d = S_IDLE;
                    end else if (s_d_c == 4'h5) begin
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (s_d_c == 4'hD && cnt_q >= CW'(PRE_MIN)) begin
                        state_d    = S_DATA;
                        half_d     = 1'b0;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end

                S_DATA: begin
                    if (s_en_c) begin
                        if (!half_q) begin
                            nib_d  = s_d_c;
                            half_d = 1'b1;
                        end else begin
                            half_d     = 1'b0;
                            pend_d     = byte_c;
                            pend_vld_d = 1'b1;
                            // Completing a byte releases the previous one.
                            if (pend_vld_q) begin
                                wr_req_c  = 1'b1;
                                wr_data_c = {1'b0, 1'b0, pend_q};
                                if (!wr_ok_c) begin
                                    error_d    = 1'b1;
                                    pend_vld_d = 1'b0;
                                    state_d    = S_DISCARD;
                                end
                            end
                        end
                    end else begin
                        state_d    = S_IDLE;
                        half_d     = 1'b0;
                        pend_vld_d = 1'b0;
                        // A held half byte means an odd nibble count.
                        if (pend_vld_q) begin
                            wr_req_c  = 1'b1;
                            wr_data_c = {1'b1, half_q | crc_bad_c, pend_q};
                            if (!wr_ok_c) begin
                                error_d = 1'b1;
                                state_d = S_DISCARD;
                            end
                        end
                    end
                end

                S_DISCARD: begin
                    if (!s_en_c) begin
                        state_d = S_IDLE;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO with registered FWFT head
    // ------------------------------------------------------------------
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] after_pop_c;
    logic          rdy_q, rdy_d;
    logic [EW-1:0] head_q, head_d;

    always_comb begin
        after_pop_c = count_q - LW'(pop_c);
        count_d     = after_pop_c + LW'(wr_en_c);
        wr_ptr_d    = wr_ptr_q + AW'(wr_en_c);
        rd_ptr_d    = rd_ptr_q + AW'(pop_c);
        rdy_d       = (count_d != '0);
        head_d      = '0;
        // A write into an otherwise-empty FIFO bypasses the memory.
        if (count_d != '0) begin
            if (after_pop_c == '0) begin
                head_d = wr_data_c;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= wr_data_c;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            clk_prev_q <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            half_q     <= 1'b0;
            nib_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rdy_q      <= 1'b0;
            head_q     <= '0;
        end else begin
            sync_q     <= sync_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            nib_q      <= nib_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            error_q    <= error_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rdy_q      <= rdy_d;
            head_q     <= head_d;
        end
    end

    assign rdy   = rdy_q;
    assign last  = head_q[9];
    assign err   = head_q[8];
    assign d     = head_q[7:0];
    assign error = error_q;
    assign level = count_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
module tb_mii_rx_deframer;

`ifdef MII_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mii_clk = 1'b0;
    logic       en_a = 1'b0, en_b = 1'b0;
    logic [3:0] nd_a = 4'h0, nd_b = 4'h0;
    logic       ack_a = 1'b0, ack_b = 1'b0;

    logic       rdy_a, last_a, err_a, error_a;
    logic [7:0] dout_a;
    logic [4:0] level_a;
    logic       rdy_b, last_b, err_b, error_b;
    logic [7:0] dout_b;
    logic [2:0] level_b;

    int checks = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    logic [3:0] nibs[$];

    always #5 clk = ~clk;
    always #40 mii_clk = ~mii_clk;

    mii_rx_deframer u_a (
        .clk(clk), .reset(reset), .mii_clk(mii_clk), .mii_en(en_a), .mii_d(nd_a),
        .rdy(rdy_a), .d(dout_a), .last(last_a), .err(err_a), .ack(ack_a),
        .error(error_a), .level(level_a)
    );

    mii_rx_deframer #(.FIRST_HIGH(0), .BIT_REVERSE(0), .DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .mii_clk(mii_clk), .mii_en(en_b), .mii_d(nd_b),
        .rdy(rdy_b), .d(dout_b), .last(last_b), .err(err_b), .ack(ack_b),
        .error(error_b), .level(level_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {rdy, last, err, d} of the selected instance
    function automatic logic [10:0] outs(input int sel);
        if (sel == 0) return {rdy_a, last_a, err_a, dout_a};
        return {rdy_b, last_b, err_b, dout_b};
    endfunction

    task automatic drive(input int sel, input logic en, input logic [3:0] n);
        if (sel == 0) begin en_a = en; nd_a = n; end
        else begin en_b = en; nd_b = n; end
    endtask

    task automatic set_ack(input int sel, input logic v);
        if (sel == 0) ack_a = v; else ack_b = v;
    endtask

    // Preamble, SFD, data nibbles, then en low for a few MII cycles.
    task automatic send_frame(input int sel, input int npre, input logic [3:0] sfd,
                              input logic [3:0] data[$]);
        logic [3:0] seq[$];
        for (int i = 0; i < npre; i++) seq.push_back(4'h5);
        seq.push_back(sfd);
        foreach (data[i]) seq.push_back(data[i]);
        foreach (seq[i]) begin
            @(negedge mii_clk);
            drive(sel, 1'b1, seq[i]);
        end
        @(negedge mii_clk);
        drive(sel, 1'b0, 4'h0);
        repeat (4) @(negedge mii_clk);
    endtask

    // Expected FIFO entries from the nibble stream: pairs form bytes, the
    // final complete byte carries last, err marks an odd count or bad CRC.
    task automatic build_exp(input logic [3:0] data[$], input bit fh, input bit br,
                             input bit crc_err);
        int nb;
        logic [3:0] f, s;
        logic [7:0] b;
        exp_q.delete();
        nb = data.size() / 2;
        for (int i = 0; i < nb; i++) begin
            f = data[2*i];
            s = data[2*i+1];
            if (br) begin
                f = {f[0], f[1], f[2], f[3]};
                s = {s[0], s[1], s[2], s[3]};
            end
            b = fh ? {f, s} : {s, f};
            if (i == nb - 1)
                exp_q.push_back({1'b1, (data.size() % 2 == 1) || crc_err, b});
            else
                exp_q.push_back({2'b00, b});
        end
    endtask

    // Pop every expected entry from the selected FIFO, checking each.
    task automatic collect(input int sel, input string tag);
        logic [10:0] o;
        int w;
        @(negedge clk);
        foreach (exp_q[i]) begin
            w = 0;
            o = outs(sel);
            while (!o[10] && w < 1500) begin
                @(negedge clk);
                w++;
                o = outs(sel);
            end
            chk($sformatf("%s.rdy[%0d]", tag, i), 32'(o[10]), 32'd1);
            chk($sformatf("%s.d[%0d]", tag, i), 32'(o[7:0]), 32'(exp_q[i][7:0]));
            chk($sformatf("%s.last[%0d]", tag, i), 32'(o[9]), 32'(exp_q[i][9]));
            if (exp_q[i][9])
                chk($sformatf("%s.err[%0d]", tag, i), 32'(o[8]), 32'(exp_q[i][8]));
            set_ack(sel, 1'b1);
            @(negedge clk);
            set_ack(sel, 1'b0);
        end
        chk($sformatf("%s.empty", tag), 32'(outs(sel) >> 10), 32'd0);
    endtask

    function automatic logic [31:0] fcs32(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    initial begin
        logic [7:0] fr[$];
        logic [31:0] f;

        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.rdy", 32'(rdy_a), 0);
        chk("rst.d", 32'(dout_a), 0);
        chk("rst.last", 32'(last_a), 0);
        chk("rst.err", 32'(err_a), 0);
        chk("rst.error", 32'(error_a), 0);
        chk("rst.level", 32'(level_a), 0);
        chk("rst.level_b", 32'(level_b), 0);

        // Basic frame, default ordering: 84, C2
        nibs = '{4'h1, 4'h2, 4'h3, 4'h4};
        build_exp(nibs, 1'b1, 1'b1, 1'b0);
        chk("basic.model0", 32'(exp_q[0][7:0]), 32'h84);
        send_frame(0, 15, 4'hD, nibs);
        chk("basic.level", 32'(level_a), 2);
        collect(0, "basic");

        // Same frame, plain ordering: 21, 43
        build_exp(nibs, 1'b0, 1'b0, 1'b0);
        send_frame(1, 15, 4'hD, nibs);
        collect(1, "plain");

        // Odd nibble count: one byte flagged as error
        nibs = '{4'h1, 4'h2, 4'h3};
        build_exp(nibs, 1'b1, 1'b1, 1'b0);
        send_frame(0, 15, 4'hD, nibs);
        collect(0, "odd");

        // Too-short preamble is discarded, next frame still received
        nibs = '{4'h1, 4'h2, 4'h3, 4'h4};
        exp_q.delete();
        send_frame(0, 1, 4'hD, nibs);
        chk("short.level", 32'(level_a), 0);
        send_frame(0, 2, 4'hD, nibs);
        build_exp(nibs, 1'b1, 1'b1, 1'b0);
        collect(0, "after_short");

        // Random frames including empty and odd-length ones
        for (int r = 0; r < 8; r++) begin
            int n;
            int np;
            n  = $urandom_range(24, 0);
            np = $urandom_range(15, 2);
            nibs.delete();
            for (int i = 0; i < n; i++) nibs.push_back(4'($urandom_range(15, 0)));
            build_exp(nibs, 1'b1, 1'b1, 1'b0);
            send_frame(0, np, 4'hD, nibs);
            chk($sformatf("rnd%0d.level", r), 32'(level_a), 32'(exp_q.size()));
            collect(0, $sformatf("rnd%0d", r));
        end

        // Overflow on the 4-deep instance with ack held low
        nibs.delete();
        for (int i = 0; i < 20; i++) nibs.push_back(4'($urandom_range(15, 0)));
        build_exp(nibs, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 4) exp_q.pop_back();
        send_frame(1, 7, 4'hD, nibs);
        chk("ovf.level", 32'(level_b), 4);
        chk("ovf.error", 32'(error_b), 1);
        collect(1, "ovf");
        nibs = '{4'h1, 4'h2, 4'h3, 4'h4};
        build_exp(nibs, 1'b0, 1'b0, 1'b0);
        send_frame(1, 7, 4'hD, nibs);
        collect(1, "post_ovf");
        chk("post_ovf.error", 32'(error_b), 1);

        // 60-byte frame with FCS, drained while it arrives
        fr.delete();
        for (int i = 0; i < 56; i++) fr.push_back(8'($urandom_range(255, 0)));
        f = fcs32(fr);
        for (int i = 0; i < 4; i++) fr.push_back(f[8*i +: 8]);
        nibs.delete();
        foreach (fr[i]) begin
            nibs.push_back(fr[i][3:0]);
            nibs.push_back(fr[i][7:4]);
        end
        build_exp(nibs, 1'b1, 1'b1, 1'b0);
        fork
            send_frame(0, 15, 4'hD, nibs);
            collect(0, "crc_ok");
        join
        nibs[20] = nibs[20] ^ 4'h1;
        build_exp(nibs, 1'b1, 1'b1, CRC_ON);
        fork
            send_frame(0, 15, 4'hD, nibs);
            collect(0, "crc_bad");
        join

        chk("end.error_a", 32'(error_a), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset.error_b", 32'(error_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mii_rx_deframer.md
# mii_rx_deframer

Parametrised successor to the byte-assembling MII receive core. Oversamples an MII receive interface in the system clock domain, strips preamble/SFD, packs nibbles into bytes with configurable nibble and bit ordering, and delivers bytes through a first-word-fall-through FIFO with per-byte end-of-frame and error tags. It sits between the RGMII/MII pins (after DDR demux) and the frame-level consumer logic.

## Interface
- SYNC_STAGES, 2: synchroniser flops on mii_clk, mii_en and mii_d (≥2).
- PRE_MIN, 2: minimum count of 4'h5 nibbles before the 4'hD SFD nibble is accepted.
- FIRST_HIGH, 1: 1 = first nibble of each byte goes to d[7:4]; 0 = d[3:0].
- BIT_REVERSE, 1: 1 = each nibble is stored bit-reversed (mii_d[3]→lowest bit of its nibble slot); 0 = stored as-is.
- DEPTH, 16: output FIFO entries, power of two, ≥2.
- clk  in  1  system clock, ≥4× mii_clk frequency.
- reset  in  1  synchronous, active-high.
- mii_clk  in  1  MII receive clock, asynchronous to clk.
- mii_en  in  1  MII receive data valid.
- mii_d  in  4  MII receive nibble.
- rdy  out  1  FIFO non-empty; d/last/err valid.
- d  out  8  output byte.
- last  out  1  byte is final byte of its frame.
- err  out  1  frame error; meaningful only when last=1.
- ack  in  1  pop head entry; ignored when rdy=0.
- error  out  1  sticky overflow flag, cleared only by reset.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Sample point: cycle where synchronised mii_clk is 1 and its previous value 0; synchronised mii_en and mii_d are captured at that cycle. All state below advances only on sample points, except FIFO reads.
- States: IDLE, PRE, DATA, DISCARD.
- IDLE: en=1 and nibble 4'h5 → PRE, count=1; en=1 with other nibble → DISCARD.
- PRE: en=0 → IDLE. Nibble 4'h5 → count++ (saturating). Nibble 4'hD with count≥PRE_MIN → DATA. Any other nibble, or 4'hD with count<PRE_MIN → DISCARD.
- DATA: alternating half flag; first nibble held, second completes a byte. Completed byte enters a one-entry pending register; the previous pending byte is written to the FIFO with last=0, err=0.
- DATA, en=0: pending byte written with last=1; err=1 if a half byte was held (odd nibble count; partial nibble dropped) or, with CRC enabled, CRC check fails. → IDLE. Frame with zero complete bytes writes nothing.
- DISCARD: ignore nibbles; en=0 → IDLE.
- Overflow: write attempted while FIFO full and no same-cycle pop → byte dropped, error←1, pending register cleared, → DISCARD.
- Full FIFO with same-cycle ack: write accepted, level unchanged.
- Empty FIFO: ack ignored.

## Timing
- Reset values: rdy 0, d 8'h00, last 0, err 0, error 0, level 0; state IDLE, FIFO empty, synchronisers cleared.
- Reset mid-frame: frame abandoned; receiver restarts in IDLE and requires a full preamble+SFD.
- Sample-point latency: SYNC_STAGES+1 clk cycles after mii_clk rises.
- Byte n (not last) is written on the sample point completing byte n+1; last byte written on the sample point seeing en=0.
- FIFO write visible at outputs (rdy=1, d valid) the cycle after the write; FWFT, ack consumes head on the same edge, next entry valid the following cycle.

## Configuration
- MII_CRC_EN defined: CRC-32 (poly 04C11DB7, init FFFFFFFF, reflected) runs over DATA nibbles in wire order, mii_d[0] first, independent of FIRST_HIGH/BIT_REVERSE; reset on SFD. At frame end, residue ≠ 32'hC704DD7B → err=1 on last byte. FCS bytes are still delivered.
- MII_CRC_EN undefined: no CRC logic; err reflects only odd-nibble termination.

## Test plan
- Defaults, clk = 8× mii_clk, preamble 15×4'h5, SFD 4'hD, nibbles 1,2,3,4, en low → two bytes; first d=8'h84 (FIRST_HIGH, BIT_REVERSE: 1→8, 2→4), last=0; second d=8'hC2, last=1, err=0.
- Same frame, FIRST_HIGH=0, BIT_REVERSE=0 → d=8'h21 then 8'h43.
- Frame with 3 data nibbles 1,2,3 → one byte, last=1, err=1; partial nibble absent.
- Preamble of 1×4'h5 then 4'hD (PRE_MIN=2) → no output; following valid frame received correctly.
- DEPTH=4, ack held 0, 10-byte frame → level=4, error=1, remaining bytes dropped; after draining, next frame delivered intact, error stays 1 until reset.
- MII_CRC_EN: 60-byte frame with correct FCS → last err=0; same frame with one payload bit flipped → last err=1.
